tdl_ctrl: RTL and testbench
===========================

TDL_CTRL -- requirements
Module: tdl_ctrl

Interface
REQ-001 Parameter DWELL, default 2, settle cycles held after each single-tap step (legal range 1..15).
REQ-002 Parameter RESET_TAP, default 0, tap index loaded at reset (legal range 0..7).
REQ-003 clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 rst  input  1  reset: synchronous, active-high.
REQ-005 req_valid  input  1  new tap request present.
REQ-006 tap_req  input  3  requested tap index 0..7.
REQ-007 req_ready  output  1  request accepted when req_valid and req_ready are both high on a rising edge.
REQ-008 lambda  output  8  tap-enable code to delay line.
REQ-009 lambda_bar  output  8  pass-through-enable code to delay line.
REQ-010 cur_tap  output  3  tap index currently fully connected.
REQ-011 busy  output  1  high while a tap move is in progress.
REQ-012 done  output  1  one-cycle pulse when a request completes.

Function
REQ-013 Code for tap t SHALL be: lambda = one-hot bit t; lambda_bar[i]=1 for i<t, 0 for i>=t; lambda_bar[7] always 0.
REQ-014 FSM states SHALL be IDLE, BREAK, MAKE, CONNECT, SETTLE; req_ready=1 only in IDLE; busy=1 in all other states.
REQ-015 On accept with tap_req==cur_tap: stay IDLE, outputs unchanged, done=1 next cycle.
REQ-016 On accept with tap_req!=cur_tap: latch target, enter BREAK next cycle, move one tap per step toward target.
REQ-017 Step up t->t+1: BREAK clears lambda[t]; MAKE sets lambda[t+1]; CONNECT sets lambda_bar[t] and cur_tap=t+1.
REQ-018 Step down t->t-1: BREAK clears lambda_bar[t-1]; MAKE clears lambda[t]; CONNECT sets lambda[t-1] and cur_tap=t-1.
REQ-019 Each BREAK/MAKE/CONNECT SHALL last exactly one cycle; SETTLE SHALL last exactly DWELL cycles; one step = 3+DWELL cycles.
REQ-020 After SETTLE: if cur_tap!=target go to BREAK, else go to IDLE with done=1 for that first IDLE cycle.
REQ-021 No two enabled buffers SHALL ever drive the same delay-line node in any cycle (break-before-make).
REQ-022 req_valid and tap_req SHALL be ignored while busy; target SHALL NOT change mid-move.
REQ-023 Moves at tap 0 or 7 SHALL never index outside 0..7; a single request may span up to 7 steps.

Reset
REQ-024 With rst high at an edge: state=IDLE, cur_tap=RESET_TAP, lambda/lambda_bar=code of RESET_TAP, busy=0, done=0, req_ready=0 during rst.
REQ-025 Reset asserted mid-move SHALL abort the move and restore RESET_TAP code on the next edge, without intermediate codes.
REQ-026 req_ready SHALL rise in the first cycle after rst deasserts.

Configuration
REQ-027 Macro TDL_CTRL_STEP_CNT_EN defined: adds output step_cnt (16 bits), +1 on each CONNECT, saturates at 0xFFFF, cleared by rst.
REQ-028 Macro TDL_CTRL_STEP_CNT_EN undefined: step_cnt port and counter are absent; all other behaviour is identical.

Verification
REQ-029 Reset, RESET_TAP=0 -> lambda=0x01, lambda_bar=0x00, cur_tap=0, busy=0, req_ready=1 after release.
REQ-030 DWELL=2, request tap 3 from 0 -> 15 busy cycles; final lambda=0x08, lambda_bar=0x07; done pulses once; req_ready returns.
REQ-031 From tap 5, request tap 4 -> BREAK lambda_bar=0x0F, MAKE lambda=0x00, CONNECT lambda=0x10; cur_tap=4 after 3+DWELL cycles.
REQ-032 Request equal to cur_tap (tap 2) -> no code change, busy stays 0, done=1 one cycle after accept.
REQ-033 Request tap 7 from 0, assert rst during third step -> next edge lambda=0x01, lambda_bar=0x00, state IDLE, no done pulse.
REQ-034 Every cycle of random request sequences -> no contention per REQ-021; with TDL_CTRL_STEP_CNT_EN, step_cnt equals total taps traversed.

Source files
------------

// File: rtl/tdl_ctrl.sv
// tdl_ctrl -- tapped-delay-line tap controller.
//
// Moves the delay-line connection point one tap at a time toward a requested
// tap, using a break-before-make sequence (BREAK, MAKE, CONNECT) followed by
// DWELL settle cycles per step, so no two enabled buffers ever drive the same
// delay-line node.
//
// Parameters:
//   DWELL      settle cycles held after each single-tap step (1..15)
//   RESET_TAP  tap index loaded at reset (0..7)
//
// Ports:
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset
//   req_valid   new tap request present
//   tap_req     requested tap index
//   req_ready   high only in IDLE (registered); accept = req_valid & req_ready
//   lambda      tap-enable code (one-hot of the connected tap)
//   lambda_bar  pass-through-enable code (bits below the connected tap)
//   cur_tap     tap index currently fully connected
//   busy        high while a tap move is in progress
//   done        one-cycle pulse when a request completes
//   step_cnt    (only with TDL_CTRL_STEP_CNT_EN) saturating count of CONNECTs
//
// Configuration macro: TDL_CTRL_STEP_CNT_EN adds the step_cnt output.

module tdl_ctrl #(
    parameter int DWELL     = 2,
    parameter int RESET_TAP = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [2:0] tap_req,
    output logic       req_ready,
    output logic [7:0] lambda,
    output logic [7:0] lambda_bar,
    output logic [2:0] cur_tap,
    output logic       busy,
    output logic       done
`ifdef TDL_CTRL_STEP_CNT_EN
    ,
    output logic [15:0] step_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_BREAK   = 3'd1,
        S_MAKE    = 3'd2,
        S_CONNECT = 3'd3,
        S_SETTLE  = 3'd4
    } state_t;

    localparam logic [2:0] RST_TAP  = 3'(RESET_TAP);
    localparam logic [3:0] DWELL_M1 = 4'(DWELL - 1);

    // Steady-state codes for a fully connected tap.
    function automatic logic [7:0] lambda_of(input logic [2:0] t);
        return 8'b0000_0001 << t;
    endfunction

    function automatic logic [7:0] lambda_bar_of(input logic [2:0] t);
        return (8'b0000_0001 << t) - 8'b0000_0001;
    endfunction

    state_t     state_r, state_s;
    logic [2:0] cur_tap_r, cur_tap_s;
    logic [2:0] target_r, target_s;
    logic [7:0] lambda_r, lambda_s;
    logic [7:0] bar_r, bar_s;
    logic [3:0] dwell_r, dwell_s;
    logic       done_r, done_s;
    logic       ready_r;
    logic       busy_r;

    logic [2:0] goal_s;
    logic       up_s;
    logic [2:0] tp1_s;
    logic [2:0] tm1_s;
    logic       accept_s;
    logic       enter_break_s;

    // Next-state and next-code logic; each edge applies the action of the state being entered.
    always_comb begin
        state_s       = state_r;
        cur_tap_s     = cur_tap_r;
        target_s      = target_r;
        lambda_s      = lambda_r;
        bar_s         = bar_r;
        dwell_s       = dwell_r;
        done_s        = 1'b0;
        enter_break_s = 1'b0;

        // In IDLE the direction comes from the incoming request, otherwise
        // from the latched target, which cannot change mid-move.
        goal_s   = (state_r == S_IDLE) ? tap_req : target_r;
        up_s     = (goal_s > cur_tap_r);
        // Wrapped neighbours are only used in the direction that exists.
        tp1_s    = cur_tap_r + 3'd1;
        tm1_s    = cur_tap_r - 3'd1;
        accept_s = req_valid && ready_r;

        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    if (tap_req == cur_tap_r) begin
                        done_s = 1'b1;
                    end else begin
                        target_s      = tap_req;
                        state_s       = S_BREAK;
                        enter_break_s = 1'b1;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_BREAK: begin
                state_s = S_MAKE;
                if (up_s) begin
                    lambda_s[tp1_s] = 1'b1;
                end else begin
                    lambda_s[cur_tap_r] = 1'b0;
                end
            end
            S_MAKE: begin
                state_s = S_CONNECT;
                if (up_s) begin
                    bar_s[cur_tap_r] = 1'b1;
                    cur_tap_s        = tp1_s;
                end else begin
                    lambda_s[tm1_s] = 1'b1;
                    cur_tap_s       = tm1_s;
                end
            end
            S_CONNECT: begin
                state_s = S_SETTLE;
                dwell_s = DWELL_M1;
            end
            S_SETTLE: begin
                if (dwell_r != 4'd0) begin
                    dwell_s = dwell_r - 4'd1;
                end else if (cur_tap_r != target_r) begin
                    state_s       = S_BREAK;
                    enter_break_s = 1'b1;
                end else begin
                    state_s = S_IDLE;
                    done_s  = 1'b1;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase

        // BREAK opens the buffer that would otherwise collide with the next tap.
        if (enter_break_s) begin
            if (up_s) begin
                lambda_s[cur_tap_r] = 1'b0;
            end else begin
                bar_s[tm1_s] = 1'b0;
            end
        end else begin
            lambda_s = lambda_s;
        end
    end

    // State and registered-output update; reset restores the RESET_TAP code directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            cur_tap_r <= RST_TAP;
            target_r  <= RST_TAP;
            lambda_r  <= lambda_of(RST_TAP);
            bar_r     <= lambda_bar_of(RST_TAP);
            dwell_r   <= 4'd0;
            done_r    <= 1'b0;
            ready_r   <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cur_tap_r <= cur_tap_s;
            target_r  <= target_s;
            lambda_r  <= lambda_s;
            bar_r     <= bar_s;
            dwell_r   <= dwell_s;
            done_r    <= done_s;
            ready_r   <= (state_s == S_IDLE);
            busy_r    <= (state_s != S_IDLE);
        end
    end

`ifdef TDL_CTRL_STEP_CNT_EN
    logic [15:0] step_cnt_r;

    // Count completed single-tap steps (entries into CONNECT), saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt_r <= 16'd0;
        end else if ((state_r == S_MAKE) && (step_cnt_r != 16'hFFFF)) begin
            step_cnt_r <= step_cnt_r + 16'd1;
        end else begin
            step_cnt_r <= step_cnt_r;
        end
    end

    assign step_cnt = step_cnt_r;
`endif

    assign req_ready  = ready_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign lambda     = lambda_r;
    assign lambda_bar = bar_r;
    assign cur_tap    = cur_tap_r;

endmodule

// File: tb/tb_tdl_ctrl.sv
// Self-checking bench for tdl_ctrl (DWELL=2, RESET_TAP=0): a table of
// requests with hand-computed final codes and busy lengths, followed by
// hand-written sequences for the per-phase codes, mid-move reset, and
// random requests with a contention check on every busy cycle.

module tb_tdl_ctrl;

    localparam int DWELL = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [2:0] tap_req;
    logic       req_ready;
    logic [7:0] lambda;
    logic [7:0] lambda_bar;
    logic [2:0] cur_tap;
    logic       busy;
    logic       done;
`ifdef TDL_CTRL_STEP_CNT_EN
    logic [15:0] step_cnt;
`endif

    int checks = 0;
    int errors = 0;

    tdl_ctrl #(.DWELL(DWELL), .RESET_TAP(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .tap_req    (tap_req),
        .req_ready  (req_ready),
        .lambda     (lambda),
        .lambda_bar (lambda_bar),
        .cur_tap    (cur_tap),
        .busy       (busy),
        .done       (done)
`ifdef TDL_CTRL_STEP_CNT_EN
        ,
        .step_cnt   (step_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] tap;
        logic [7:0] exp_lambda;
        logic [7:0] exp_bar;
        int         exp_busy;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Break-before-make: at most one tap enabled, no tap also passed through,
    // top pass-through never enabled.
    task automatic chk_contention();
        int ok;
        ok = ($countones(lambda) <= 1) && ((lambda & lambda_bar) == 8'h00)
             && (lambda_bar[7] == 1'b0);
        chk("no_contention", ok, 1);
    endtask

    // Issue one request, then count busy cycles and done pulses while
    // driving garbage requests that must be ignored.
    task automatic run_req(input logic [2:0] t, output int nbusy, output int ndone);
        chk("ready_before_accept", int'(req_ready), 1);
        req_valid = 1'b1;
        tap_req   = t;
        tick();
        nbusy = 0;
        ndone = 0;
        while (busy && nbusy < 200) begin
            nbusy++;
            if (done) ndone++;
            chk_contention();
            chk("ready_low_busy", int'(req_ready), 0);
            req_valid = 1'b1;
            tap_req   = 3'($urandom_range(0, 7));
            tick();
        end
        req_valid = 1'b0;
        if (nbusy >= 200) chk("busy_timeout", nbusy, 0);
        if (done) ndone++;
        chk("ready_after_req", int'(req_ready), 1);
        tick();
        if (done) ndone++;
    endtask

    initial begin
        int nb;
        int nd;
        int model_tap;
        int steps;
        int total;
        logic [2:0] t;
        logic [7:0] one8;

        vecs[0] = '{3'd3, 8'h08, 8'h07, 15};
        vecs[1] = '{3'd5, 8'h20, 8'h1F, 10};
        vecs[2] = '{3'd4, 8'h10, 8'h0F, 5};
        vecs[3] = '{3'd4, 8'h10, 8'h0F, 0};
        vecs[4] = '{3'd7, 8'h80, 8'h7F, 15};
        vecs[5] = '{3'd0, 8'h01, 8'h00, 35};
        vecs[6] = '{3'd2, 8'h04, 8'h03, 10};
        vecs[7] = '{3'd2, 8'h04, 8'h03, 0};

        rst       = 1'b1;
        req_valid = 1'b0;
        tap_req   = 3'd0;
        tick();
        tick();
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_lambda", int'(lambda), 8'h01);
        chk("rst_lambda_bar", int'(lambda_bar), 8'h00);
        chk("rst_cur_tap", int'(cur_tap), 0);
        rst = 1'b0;
        tick();
        chk("rel_ready", int'(req_ready), 1);
        chk("rel_busy", int'(busy), 0);
        chk("rel_lambda", int'(lambda), 8'h01);

        // Table of requests from tap 0.
        for (int i = 0; i < 8; i++) begin
            run_req(vecs[i].tap, nb, nd);
            chk("vec_busy_cycles", nb, vecs[i].exp_busy);
            chk("vec_done_pulses", nd, 1);
            chk("vec_cur_tap", int'(cur_tap), int'(vecs[i].tap));
            chk("vec_lambda", int'(lambda), int'(vecs[i].exp_lambda));
            chk("vec_lambda_bar", int'(lambda_bar), int'(vecs[i].exp_bar));
        end

        // Equal request at tap 2: no code change, done one cycle after accept.
        req_valid = 1'b1;
        tap_req   = 3'd2;
        tick();
        req_valid = 1'b0;
        chk("eq_busy", int'(busy), 0);
        chk("eq_done", int'(done), 1);
        chk("eq_lambda", int'(lambda), 8'h04);
        tick();
        chk("eq_done_clear", int'(done), 0);

        // Step down 5 -> 4, phase by phase.
        run_req(3'd5, nb, nd);
        req_valid = 1'b1;
        tap_req   = 3'd4;
        tick();
        req_valid = 1'b0;
        chk("dn_break_lambda", int'(lambda), 8'h20);
        chk("dn_break_bar", int'(lambda_bar), 8'h0F);
        chk("dn_break_busy", int'(busy), 1);
        chk("dn_break_cur", int'(cur_tap), 5);
        tick();
        chk("dn_make_lambda", int'(lambda), 8'h00);
        chk("dn_make_bar", int'(lambda_bar), 8'h0F);
        tick();
        chk("dn_conn_lambda", int'(lambda), 8'h10);
        chk("dn_conn_cur", int'(cur_tap), 4);
        tick();
        chk("dn_settle1_busy", int'(busy), 1);
        tick();
        chk("dn_settle2_busy", int'(busy), 1);
        chk("dn_settle2_done", int'(done), 0);
        tick();
        chk("dn_idle_busy", int'(busy), 0);
        chk("dn_idle_done", int'(done), 1);
        tick();
        chk("dn_done_clear", int'(done), 0);

        // Back to 0, then request 7 and reset during the third step.
        run_req(3'd0, nb, nd);
        chk("back0_busy", nb, 20);
        req_valid = 1'b1;
        tap_req   = 3'd7;
        tick();
        req_valid = 1'b0;
        repeat (11) tick();
        chk("mid_cur_tap", int'(cur_tap), 2);
        chk("mid_lambda", int'(lambda), 8'h08);
        chk("mid_bar", int'(lambda_bar), 8'h03);
        rst = 1'b1;
        tick();
        chk("abort_lambda", int'(lambda), 8'h01);
        chk("abort_bar", int'(lambda_bar), 8'h00);
        chk("abort_cur", int'(cur_tap), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_ready", int'(req_ready), 0);
        tick();
        chk("abort_ready2", int'(req_ready), 0);
        rst = 1'b0;
        tick();
        chk("abort_rel_ready", int'(req_ready), 1);
        chk("abort_rel_done", int'(done), 0);

        // Random requests with a reference tap model.
        model_tap = 0;
        total     = 0;
        one8      = 8'h01;
        for (int k = 0; k < 12; k++) begin
            t     = 3'($urandom_range(0, 7));
            steps = (int'(t) > model_tap) ? (int'(t) - model_tap) : (model_tap - int'(t));
            run_req(t, nb, nd);
            chk("rnd_busy_cycles", nb, steps * (3 + DWELL));
            chk("rnd_done_pulses", nd, 1);
            chk("rnd_cur_tap", int'(cur_tap), int'(t));
            chk("rnd_lambda", int'(lambda), int'(one8 << t));
            chk("rnd_lambda_bar", int'(lambda_bar), int'((one8 << t) - 8'h01));
            model_tap = int'(t);
            total     = total + steps;
        end
`ifdef TDL_CTRL_STEP_CNT_EN
        chk("step_cnt", int'(step_cnt), total);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
